fb_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single frame-buffer pixel write port between NUM_REQ drawing engines (background, lava, player, HUD).
- Each engine presents one pixel (x, y, color) per valid/ack handshake.
- The arbiter grants bounded bursts per owner, drops off-screen pixels and drives a registered write port into the frame-buffer RAM read by the VGA scan logic.

---
 rtl/fb_pkg.sv | 21 ++
 rtl/rr_picker.sv | 35 +++
 rtl/fb_write_arbiter.sv | 128 ++++++++++++
 tb/tb_fb_write_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and frame geometry for the frame-buffer write arbiter.
package fb_pkg;

   localparam int X_W     = 10;
   localparam int Y_W     = 10;
   localparam int COLOR_W = 3;
   localparam int X_MAX   = 640;
   localparam int Y_MAX   = 480;

   typedef enum logic {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   typedef struct packed {
      logic [X_W-1:0]     x;
      logic [Y_W-1:0]     y;
      logic [COLOR_W-1:0] color;
   } pixel_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: rotate req so last+1 sits at bit 0, take the lowest set
// bit, then rotate the index back.
module rr_picker #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last,
   output logic                       found,
   output logic [$clog2(NUM_REQ)-1:0] next
);

   localparam int IW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] w_rot;
   int                 w_off;

   always_comb begin
      w_rot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_rot[i] = req[IW'((int'(last) + 1 + i) % NUM_REQ)];
      end

      found = 1'b0;
      w_off = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            found = 1'b1;
            w_off = i;
         end
      end

      next = IW'((int'(last) + 1 + w_off) % NUM_REQ);
   end

endmodule

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the frame-buffer pixel write port between drawing
// engines. Define FB_VBLANK_GATE_EN to accept pixels only while blank is high.
//
// state | meaning
// IDLE  | arbitration bubble: pick next owner from last+1, no ack
// SERVE | owner holds the port, pixels accepted up to BURST_MAX
module fb_write_arbiter
   import fb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int BURST_MAX = 8
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*X_W-1:0]       req_x,
   input  logic [NUM_REQ*Y_W-1:0]       req_y,
   input  logic [NUM_REQ*COLOR_W-1:0]   req_color,
   input  logic                         blank,
   output logic [NUM_REQ-1:0]           ack,
   output logic                         fb_we,
   output logic [X_W-1:0]               fb_x,
   output logic [Y_W-1:0]               fb_y,
   output logic [COLOR_W-1:0]           fb_color,
   output logic [$clog2(NUM_REQ)-1:0]   owner,
   output logic                         busy,
   output logic [15:0]                  drop_cnt
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int BW = $clog2(BURST_MAX + 1);

   state_t          r_state;
   logic [IW-1:0]   r_owner;
   logic [IW-1:0]   r_last;
   logic [BW-1:0]   r_burst;
   logic            r_fb_we;
   pixel_t          r_fb;
   logic [15:0]     r_drop;

   logic            w_found;
   logic [IW-1:0]   w_next;
   logic            w_gate;
   logic            w_accept;
   logic            w_in_range;
   logic            w_burst_done;
   pixel_t          w_pix;

`ifdef FB_VBLANK_GATE_EN
   assign w_gate = blank;
`else
   logic w_unused_blank;
   assign w_unused_blank = blank;
   assign w_gate         = 1'b1;
`endif

   rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req   (req),
      .last  (r_last),
      .found (w_found),
      .next  (w_next)
   );

   assign w_pix.x     = req_x[r_owner*X_W +: X_W];
   assign w_pix.y     = req_y[r_owner*Y_W +: Y_W];
   assign w_pix.color = req_color[r_owner*COLOR_W +: COLOR_W];

   assign w_in_range   = (32'(w_pix.x) < X_MAX) && (32'(w_pix.y) < Y_MAX);
   assign w_accept     = (r_state == SERVE) && req[r_owner] && w_gate;
   assign w_burst_done = (r_burst == BW'(BURST_MAX - 1));

   always_comb begin
      ack          = '0;
      ack[r_owner] = w_accept;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_owner <= '0;
         r_last  <= IW'(NUM_REQ - 1);
         r_burst <= '0;
         r_fb_we <= 1'b0;
         r_fb    <= '0;
         r_drop  <= '0;
      end else begin
         r_fb_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_owner <= w_next;
                  r_burst <= '0;
                  r_state <= SERVE;
               end
            end
            SERVE: begin
               if (!req[r_owner]) begin
                  r_state <= IDLE;
                  r_last  <= r_owner;
               end else if (w_accept) begin
                  r_burst <= r_burst + 1'b1;
                  if (w_in_range) begin
                     r_fb_we <= 1'b1;
                     r_fb    <= w_pix;
                  end else if (r_drop != 16'hFFFF) begin
                     r_drop <= r_drop + 16'd1;
                  end
                  // Forced rotation keeps one engine from starving the rest
                  if (w_burst_done) begin
                     r_state <= IDLE;
                     r_last  <= r_owner;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign fb_we    = r_fb_we;
   assign fb_x     = r_fb.x;
   assign fb_y     = r_fb.y;
   assign fb_color = r_fb.color;
   assign owner    = r_owner;
   assign busy     = (r_state == SERVE);
   assign drop_cnt = r_drop;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: one instance with BURST_MAX=8, one with 2.
module tb_fb_write_arbiter;
   import fb_pkg::*;

   localparam int N = 4;

   logic                   clk = 1'b0;
   logic                   resetn = 1'b0;
   logic [N-1:0]           req = '0;
   logic [N*X_W-1:0]       req_x = '0;
   logic [N*Y_W-1:0]       req_y = '0;
   logic [N*COLOR_W-1:0]   req_color = '0;
   logic                   blank = 1'b0;

   logic [N-1:0]           ack, ack2;
   logic                   fb_we, fb_we2;
   logic [X_W-1:0]         fb_x, fb_x2;
   logic [Y_W-1:0]         fb_y, fb_y2;
   logic [COLOR_W-1:0]     fb_color, fb_color2;
   logic [1:0]             owner, owner2;
   logic                   busy, busy2;
   logic [15:0]            drop_cnt, drop_cnt2;

   int n_pass = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   fb_write_arbiter #(.NUM_REQ(N), .BURST_MAX(8)) u_dut (
      .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .blank(blank), .ack(ack), .fb_we(fb_we),
      .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .owner(owner),
      .busy(busy), .drop_cnt(drop_cnt)
   );

   fb_write_arbiter #(.NUM_REQ(N), .BURST_MAX(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .req(req), .req_x(req_x), .req_y(req_y),
      .req_color(req_color), .blank(blank), .ack(ack2), .fb_we(fb_we2),
      .fb_x(fb_x2), .fb_y(fb_y2), .fb_color(fb_color2), .owner(owner2),
      .busy(busy2), .drop_cnt(drop_cnt2)
   );

   task automatic set_pix(input int i, input int x, input int y, input int c);
      req_x[i*X_W +: X_W]             = X_W'(x);
      req_y[i*Y_W +: Y_W]             = Y_W'(y);
      req_color[i*COLOR_W +: COLOR_W] = COLOR_W'(c);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      req    = '0;
      blank  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      resetn = 1'b0;
      req    = 4'b1111;
      set_pix(0, 1, 2, 3);
      #1;
      n_total++; if (fb_we !== 1'b0) $display("FAIL reset_we got=%b want=0", fb_we); else n_pass++;
      n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else n_pass++;
      n_total++; if (owner !== 2'd0) $display("FAIL reset_owner got=%0d want=0", owner); else n_pass++;
      n_total++; if (ack !== 4'b0000) $display("FAIL reset_ack got=%b want=0000", ack); else n_pass++;
      n_total++; if (drop_cnt !== 16'd0) $display("FAIL reset_drop got=%0d want=0", drop_cnt); else n_pass++;
      n_total++; if (fb_x !== 10'd0 || fb_y !== 10'd0 || fb_color !== 3'd0)
         $display("FAIL reset_fb got=%0d,%0d,%0d want=0,0,0", fb_x, fb_y, fb_color); else n_pass++;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL reset_hold_busy got=%b want=0", busy); else n_pass++;
      resetn = 1'b1;
      req    = '0;
   endtask

   task automatic test_single();
      do_reset();
      set_pix(2, 10, 20, 3);
      req = 4'b0100;
      #1;
      n_total++; if (ack !== 4'b0000) $display("FAIL single_bubble got=%b want=0000", ack); else n_pass++;
      @(negedge clk); #1;
      n_total++; if (busy !== 1'b1 || owner !== 2'd2)
         $display("FAIL single_grant got=busy%b/own%0d want=busy1/own2", busy, owner); else n_pass++;
      n_total++; if (ack !== 4'b0100) $display("FAIL single_ack0 got=%b want=0100", ack); else n_pass++;
      n_total++; if (fb_we !== 1'b0) $display("FAIL single_we0 got=%b want=0", fb_we); else n_pass++;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_total++; if (fb_we !== 1'b1 || fb_x !== X_W'(10 + k) || fb_y !== 10'd20 || fb_color !== 3'd3)
            $display("FAIL single_write%0d got=we%b %0d,%0d,%0d want=we1 %0d,20,3",
                     k, fb_we, fb_x, fb_y, fb_color, 10 + k);
         else n_pass++;
         if (k < 2) set_pix(2, 11 + k, 20, 3);
         else req = '0;
         #1;
         n_total++; if (ack !== ((k < 2) ? 4'b0100 : 4'b0000))
            $display("FAIL single_ack%0d got=%b want=%b", k + 1, ack, (k < 2) ? 4'b0100 : 4'b0000);
         else n_pass++;
      end
      @(negedge clk);
      n_total++; if (fb_we !== 1'b0 || busy !== 1'b0)
         $display("FAIL single_end got=we%b/busy%b want=we0/busy0", fb_we, busy); else n_pass++;
   endtask

   task automatic test_contention();
      logic [3:0] exp_ack [10];
      int         exp_own [10];
      exp_ack = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0010,
                  4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
      exp_own = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
      do_reset();
      set_pix(0, 1, 1, 1);
      set_pix(1, 2, 2, 2);
      req = 4'b0011;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_total++; if (ack2 !== exp_ack[c])
            $display("FAIL cont_ack c%0d got=%b want=%b", c, ack2, exp_ack[c]); else n_pass++;
         n_total++; if (int'(owner2) !== exp_own[c])
            $display("FAIL cont_owner c%0d got=%0d want=%0d", c, owner2, exp_own[c]); else n_pass++;
         if (c > 0) begin
            n_total++; if (fb_we2 !== (exp_ack[c-1] != 4'b0000))
               $display("FAIL cont_we c%0d got=%b want=%b", c, fb_we2, exp_ack[c-1] != 4'b0000);
            else n_pass++;
         end
      end
      req = '0;
   endtask

   task automatic test_offscreen();
      do_reset();
      set_pix(0, 640, 5, 1);
      req = 4'b0001;
      @(negedge clk); #1;
      n_total++; if (ack !== 4'b0001) $display("FAIL off_ack0 got=%b want=0001", ack); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b0 || drop_cnt !== 16'd1)
         $display("FAIL off_drop1 got=we%b/drop%0d want=we0/drop1", fb_we, drop_cnt); else n_pass++;
      set_pix(0, 639, 479, 7);
      #1;
      n_total++; if (ack !== 4'b0001) $display("FAIL off_ack1 got=%b want=0001", ack); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b1 || fb_x !== 10'd639 || fb_y !== 10'd479 || fb_color !== 3'd7)
         $display("FAIL off_edge got=we%b %0d,%0d,%0d want=we1 639,479,7", fb_we, fb_x, fb_y, fb_color);
      else n_pass++;
      n_total++; if (drop_cnt !== 16'd1) $display("FAIL off_drop_keep got=%0d want=1", drop_cnt); else n_pass++;
      set_pix(0, 5, 480, 2);
      @(negedge clk);
      n_total++; if (fb_we !== 1'b0 || drop_cnt !== 16'd2 || fb_x !== 10'd639)
         $display("FAIL off_ydrop got=we%b/drop%0d/x%0d want=we0/drop2/x639", fb_we, drop_cnt, fb_x);
      else n_pass++;
      req = '0;
   endtask

   task automatic test_wrap();
      do_reset();
      set_pix(3, 3, 3, 3);
      req = 4'b1000;
      @(negedge clk); #1;
      n_total++; if (owner !== 2'd3 || ack !== 4'b1000)
         $display("FAIL wrap_own3 got=own%0d/ack%b want=own3/ack1000", owner, ack); else n_pass++;
      @(negedge clk);
      req = '0;
      @(negedge clk);
      n_total++; if (busy !== 1'b0) $display("FAIL wrap_release got=%b want=0", busy); else n_pass++;
      req = 4'b1111;
      @(negedge clk); #1;
      n_total++; if (owner !== 2'd0 || ack !== 4'b0001)
         $display("FAIL wrap_own0 got=own%0d/ack%b want=own0/ack0001", owner, ack); else n_pass++;
      req = '0;
      do_reset();
      req = 4'b0010;
      @(negedge clk);
      @(negedge clk);
      req = '0;
      @(negedge clk);
      req = 4'b1101;
      @(negedge clk); #1;
      n_total++; if (owner !== 2'd2 || ack !== 4'b0100)
         $display("FAIL wrap_after1 got=own%0d/ack%b want=own2/ack0100", owner, ack); else n_pass++;
      req = '0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      set_pix(1, 7, 8, 5);
      req = 4'b0010;
      @(negedge clk); #1;
      n_total++; if (owner !== 2'd1) $display("FAIL mid_own1 got=%0d want=1", owner); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b1) $display("FAIL mid_we got=%b want=1", fb_we); else n_pass++;
      resetn = 1'b0;
      #1;
      n_total++; if (fb_we !== 1'b0 || busy !== 1'b0 || owner !== 2'd0 || ack !== 4'b0000)
         $display("FAIL mid_async got=we%b/busy%b/own%0d/ack%b want=we0/busy0/own0/ack0000",
                  fb_we, busy, owner, ack);
      else n_pass++;
      req = 4'b1111;
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk); #1;
      n_total++; if (owner !== 2'd0 || busy !== 1'b1 || ack !== 4'b0001)
         $display("FAIL mid_regrant got=own%0d/busy%b/ack%b want=own0/busy1/ack0001", owner, busy, ack);
      else n_pass++;
      req = '0;
   endtask

`ifdef FB_VBLANK_GATE_EN
   task automatic test_gate();
      do_reset();
      blank = 1'b0;
      set_pix(0, 4, 4, 4);
      req = 4'b0001;
      @(negedge clk); #1;
      n_total++; if (busy !== 1'b1 || ack !== 4'b0000)
         $display("FAIL gate_hold got=busy%b/ack%b want=busy1/ack0000", busy, ack); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b0 || ack !== 4'b0000)
         $display("FAIL gate_nowe got=we%b/ack%b want=we0/ack0000", fb_we, ack); else n_pass++;
      blank = 1'b1;
      #1;
      n_total++; if (ack !== 4'b0001) $display("FAIL gate_ack got=%b want=0001", ack); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b1 || fb_x !== 10'd4)
         $display("FAIL gate_we got=we%b/x%0d want=we1/x4", fb_we, fb_x); else n_pass++;
      req   = '0;
      blank = 1'b0;
   endtask
`else
   task automatic test_gate();
      do_reset();
      blank = 1'b0;
      set_pix(0, 4, 4, 4);
      req = 4'b0001;
      @(negedge clk); #1;
      n_total++; if (ack !== 4'b0001)
         $display("FAIL nogate_ack got=%b want=0001", ack); else n_pass++;
      @(negedge clk);
      n_total++; if (fb_we !== 1'b1 || fb_x !== 10'd4)
         $display("FAIL nogate_we got=we%b/x%0d want=we1/x4", fb_we, fb_x); else n_pass++;
      req = '0;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_offscreen();
      test_wrap();
      test_reset_mid_burst();
      test_gate();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
